// File: rtl/rv32_pkg.sv
// Shared widths, arbiter state encoding and the bypass capture record used by the
// register file arbiter.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StForce,
    StResp
  } arb_state_t;

  // Everything needed one cycle later to patch a registered read result.
  typedef struct packed {
    logic            hit0;
    logic            zero0;
    logic            hit1;
    logic            zero1;
    logic            owner_dbg;
    logic [3:0]      be;
    logic [XLEN-1:0] data;
  } byp_t;

endpackage

// File: rtl/rf_bypass_merge.sv
// Patches a registered register-file read word with a same-cycle write and forces x0 to zero.
module rf_bypass_merge
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [3:0]      be_i,
  input  logic            hit_i,
  input  logic            zero_i,
  output logic [XLEN-1:0] merged_o
);

  always_comb begin
    merged_o = rf_data_i;
    if (zero_i) begin
      merged_o = '0;
    end else if (hit_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) merged_o[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares register file read channel 1 and the write port between the CPU and the debug host,
// with write-to-read bypass, x0 forcing and a bounded debug wait.
module reg_file_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd_en0,
  input  logic [ADDR_W-1:0] cpu_rd_addr0,
  output logic [XLEN-1:0]   cpu_rd_data0,
  input  logic              cpu_rd_en1,
  input  logic [ADDR_W-1:0] cpu_rd_addr1,
  output logic [XLEN-1:0]   cpu_rd_data1,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [3:0]        cpu_byte_en,
  input  logic [XLEN-1:0]   cpu_wr_data,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic              rf_rd_en0,
  output logic [ADDR_W-1:0] rf_rd_addr0,
  output logic              rf_rd_en1,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [3:0]        rf_byte_en,
  output logic [XLEN-1:0]   rf_wr_data,
  input  logic [XLEN-1:0]   rf_rd_data0,
  input  logic [XLEN-1:0]   rf_rd_data1
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  byp_t            byp_q, byp_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;

  logic stall, dbg_issue, dbg_free;
  logic cpu_rd0, cpu_rd1, cpu_wr, dbg_rd, dbg_wr, wr_any;
  logic [XLEN-1:0] dbg_merged;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    dbg_issue  = 1'b0;
    dbg_rvalid = 1'b0;
    dbg_free   = dbg_we ? !cpu_wr_en : !cpu_rd_en1;
    unique case (state_q)
      StIdle: begin
        if (dbg_req && dbg_free) begin
          dbg_issue = 1'b1;
          state_d   = dbg_we ? StIdle : StResp;
        end else if (dbg_req) begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (!dbg_req) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (dbg_free) begin
          dbg_issue = 1'b1;
          state_d   = dbg_we ? StIdle : StResp;
          cnt_d     = '0;
        end else if (cnt_q == CntW'(MAX_WAIT)) begin
          state_d = StForce;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StForce: begin
        stall     = 1'b1;
        dbg_issue = dbg_req;
        state_d   = (dbg_req && !dbg_we) ? StResp : StIdle;
        cnt_d     = '0;
      end
      StResp: begin
        dbg_rvalid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Nothing reaches the register file or the requesters while reset is applied.
    if (!rst) begin
      stall      = 1'b0;
      dbg_issue  = 1'b0;
      dbg_rvalid = 1'b0;
    end
  end

  assign cpu_stall = stall;
  assign dbg_gnt   = dbg_issue;

  assign cpu_rd0 = rst && cpu_rd_en0 && !stall;
  assign cpu_rd1 = rst && cpu_rd_en1 && !stall;
  assign cpu_wr  = rst && cpu_wr_en && !stall;
  assign dbg_rd  = dbg_issue && !dbg_we;
  assign dbg_wr  = dbg_issue && dbg_we;
  assign wr_any  = cpu_wr || dbg_wr;

  assign rf_rd_en0   = cpu_rd0;
  assign rf_rd_addr0 = cpu_rd_addr0;
  assign rf_rd_en1   = cpu_rd1 || dbg_rd;
  assign rf_rd_addr1 = dbg_rd ? dbg_addr : cpu_rd_addr1;
  assign rf_wr_addr  = dbg_wr ? dbg_addr : cpu_wr_addr;
  assign rf_byte_en  = dbg_wr ? 4'hF : cpu_byte_en;
  assign rf_wr_data  = dbg_wr ? dbg_wdata : cpu_wr_data;
  assign rf_wr_en    = wr_any && (rf_wr_addr != '0);

  always_comb begin
    byp_d.hit0      = cpu_rd0 && wr_any && (rf_wr_addr == cpu_rd_addr0);
    byp_d.zero0     = cpu_rd0 && (cpu_rd_addr0 == '0);
    byp_d.hit1      = rf_rd_en1 && wr_any && (rf_wr_addr == rf_rd_addr1);
    byp_d.zero1     = rf_rd_en1 && (rf_rd_addr1 == '0);
    byp_d.owner_dbg = dbg_rd;
    byp_d.be        = rf_byte_en;
    byp_d.data      = rf_wr_data;
  end

  assign dbg_rdata   = dbg_rvalid ? dbg_merged : dbg_rdata_q;
  assign dbg_rdata_d = dbg_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      byp_q       <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byp_q       <= byp_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  rf_bypass_merge u_merge_cpu0 (
    .rf_data_i (rf_rd_data0),
    .wr_data_i (byp_q.data),
    .be_i      (byp_q.be),
    .hit_i     (byp_q.hit0),
    .zero_i    (byp_q.zero0),
    .merged_o  (cpu_rd_data0)
  );

  // The owner flag zeroes channel 1 on whichever side did not issue the read.
  rf_bypass_merge u_merge_cpu1 (
    .rf_data_i (rf_rd_data1),
    .wr_data_i (byp_q.data),
    .be_i      (byp_q.be),
    .hit_i     (byp_q.hit1),
    .zero_i    (byp_q.zero1 || byp_q.owner_dbg),
    .merged_o  (cpu_rd_data1)
  );

  rf_bypass_merge u_merge_dbg (
    .rf_data_i (rf_rd_data1),
    .wr_data_i (byp_q.data),
    .be_i      (byp_q.be),
    .hit_i     (byp_q.hit1),
    .zero_i    (byp_q.zero1 || !byp_q.owner_dbg),
    .merged_o  (dbg_merged)
  );

endmodule
